// File: rtl/hello_scroller_if.sv
// Character-scroller bundle: switch inputs toward the scroller, decoder codes and status back out.
// Master drives SW; slave (the scroller) drives CODES, STEP_PULSE and PAUSED.
interface hello_scroller_if;
  logic [1:0]  SW;
  logic [23:0] CODES;
  logic        STEP_PULSE;
  logic        PAUSED;

  modport master (
    output SW,
    input  CODES,
    input  STEP_PULSE,
    input  PAUSED
  );

  modport slave (
    input  SW,
    output CODES,
    output STEP_PULSE,
    output PAUSED
  );
endinterface

// File: rtl/hello_scroller.sv
// Rotating 8-slot "HELLO   " code source for per-digit HELO decoders; outputs registered, 1 cycle after rotating edge.
// No backpressure: rotates on prescaler wrap (RUN) or debounced KEY[1] press (PAUSE); SW effects land 3 cycles late.
module hello_scroller #(
  parameter int TICK_COUNT     = 25_000_000,
  parameter int DEBOUNCE_COUNT = 500_000
) (
  input  logic        CLOCK_50,
  input  logic [1:0]  KEY,
  hello_scroller_if.slave bus
);

  localparam int TW = (TICK_COUNT > 2) ? $clog2(TICK_COUNT) : 1;
  localparam int DW = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_COUNT - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_COUNT - 1);
  localparam logic [23:0]   RESET_MSG = 24'h0527FF;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic          rst_n;
  logic [1:0]    sw_s1, sw_s2;
  logic          key_s1, key_s2;
  logic          key_acc;
  logic [DW-1:0] deb_cnt;
  logic          key_flip;
  logic          press;
  logic          press_q;
  logic [TW-1:0] presc, presc_nxt;
  logic          rotate;
  logic [23:0]   codes_q;
  logic [23:0]   codes_rot;
  logic          step_q;
  logic          paused_q;

  assign rst_n = KEY[0];

  // A level change is accepted once it has held for DEBOUNCE_COUNT synced cycles.
  assign key_flip = (key_s2 != key_acc) && (deb_cnt == DEB_LAST);
  assign press    = key_flip && !key_s2;

  // Left moves each code up one slot; right moves each code down one slot.
  assign codes_rot = sw_s2[1] ? {codes_q[2:0], codes_q[23:3]}
                              : {codes_q[20:0], codes_q[23:21]};

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    rotate    = 1'b0;
    case (state)
      RUN: begin
        if (presc == TICK_LAST) begin
          presc_nxt = '0;
          rotate    = 1'b1;
        end else begin
          presc_nxt = presc + 1'b1;
        end
        if (sw_s2[0]) begin
          state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        // Leaving PAUSE takes priority over a pending press.
        if (!sw_s2[0]) begin
          state_nxt = RUN;
        end else if (press_q) begin
          rotate = 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state <= RUN;
      presc <= '0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      sw_s1   <= 2'b00;
      sw_s2   <= 2'b00;
      key_s1  <= 1'b1;
      key_s2  <= 1'b1;
      key_acc <= 1'b1;
      deb_cnt <= '0;
      press_q <= 1'b0;
    end else begin
      sw_s1   <= bus.SW;
      sw_s2   <= sw_s1;
      key_s1  <= KEY[1];
      key_s2  <= key_s1;
      press_q <= press;
      if (key_s2 == key_acc) begin
        deb_cnt <= '0;
      end else if (key_flip) begin
        key_acc <= key_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      codes_q  <= RESET_MSG;
      step_q   <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      if (rotate) begin
        codes_q <= codes_rot;
      end
      step_q   <= rotate;
      paused_q <= (state_nxt == PAUSE);
    end
  end

  assign bus.CODES      = codes_q;
  assign bus.STEP_PULSE = step_q;
  assign bus.PAUSED     = paused_q;

endmodule

// File: tb/tb_hello_scroller.sv
// Directed bench for hello_scroller with TICK_COUNT=4, DEBOUNCE_COUNT=3, plus a rotation scoreboard.
module tb_hello_scroller;

  logic       clk = 1'b0;
  logic [1:0] key = 2'b00;
  int         n_checks = 0;
  int         n_pass   = 0;

  hello_scroller_if bus();

  hello_scroller #(
    .TICK_COUNT    (4),
    .DEBOUNCE_COUNT(3)
  ) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] sw);
    bus.SW = sw;
    key    = 2'b10;
    tick(2);
    key[0] = 1'b1;
  endtask

  function automatic bit is_rot(input logic [23:0] a, input logic [23:0] b);
    return (b == {a[20:0], a[23:21]}) || (b == {a[2:0], a[23:3]});
  endfunction

  function automatic bit legal(input logic [23:0] c);
    logic [2:0] s;
    for (int i = 0; i < 8; i++) begin
      s = c[3*i +: 3];
      if (!(s inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b111})) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Scoreboard: every CODES change carries STEP_PULSE and is a single-slot rotation of legal codes.
  logic [23:0] prev_codes;
  bit          rst_seen = 1'b1;

  always @(posedge clk) rst_seen = !key[0];

  always @(negedge clk) begin
    if (!rst_seen && ((bus.CODES != prev_codes) || bus.STEP_PULSE)) begin
      check("sb_pulse", 32'(bus.STEP_PULSE), 32'd1);
      check("sb_rotate", 32'(is_rot(prev_codes, bus.CODES)), 32'd1);
      check("sb_legal", 32'(legal(bus.CODES)), 32'd1);
    end
    prev_codes = bus.CODES;
  end

  initial begin
    bus.SW = 2'b00;

    // Reset state and left rotation period
    do_reset(2'b00);
    check("rst_codes", 32'(bus.CODES), 32'h0527FF);
    check("rst_paused", 32'(bus.PAUSED), 32'd0);
    check("rst_step", 32'(bus.STEP_PULSE), 32'd0);
    tick(3);
    check("t1_hold", 32'(bus.CODES), 32'h0527FF);
    tick(1);
    check("t1_rot1", 32'(bus.CODES), 32'h293FF8);
    check("t1_pulse", 32'(bus.STEP_PULSE), 32'd1);
    tick(1);
    check("t1_pulse_end", 32'(bus.STEP_PULSE), 32'd0);
    tick(3);
    check("t1_rot2", 32'(bus.CODES), 32'h49FFC1);

    // Right rotation and full wrap
    do_reset(2'b10);
    tick(4);
    check("t2_right", 32'(bus.CODES), 32'hE0A4FF);
    check("t2_pulse", 32'(bus.STEP_PULSE), 32'd1);
    tick(28);
    check("t2_wrap", 32'(bus.CODES), 32'h0527FF);

    // Pause lands on the wrap edge: rotation still happens
    do_reset(2'b00);
    tick(1);
    bus.SW = 2'b01;
    tick(3);
    check("t3a_paused", 32'(bus.PAUSED), 32'd1);
    check("t3a_codes", 32'(bus.CODES), 32'h293FF8);
    check("t3a_pulse", 32'(bus.STEP_PULSE), 32'd1);
    tick(100);
    check("t3a_frozen", 32'(bus.CODES), 32'h293FF8);
    check("t3a_still_paused", 32'(bus.PAUSED), 32'd1);

    // Pause mid-count, resume with the held prescaler value
    do_reset(2'b00);
    bus.SW = 2'b01;
    tick(2);
    check("t3b_not_yet", 32'(bus.PAUSED), 32'd0);
    tick(1);
    check("t3b_paused", 32'(bus.PAUSED), 32'd1);
    tick(100);
    check("t3b_frozen", 32'(bus.CODES), 32'h0527FF);
    bus.SW = 2'b00;
    tick(3);
    check("t3b_running", 32'(bus.PAUSED), 32'd0);
    check("t3b_no_rot", 32'(bus.CODES), 32'h0527FF);
    tick(1);
    check("t3b_resume", 32'(bus.CODES), 32'h293FF8);

    // Paused single-step via debounced press
    do_reset(2'b00);
    bus.SW = 2'b01;
    tick(3);
    key[1] = 1'b0;
    tick(5);
    check("t4_wait", 32'(bus.CODES), 32'h0527FF);
    tick(1);
    check("t4_press", 32'(bus.CODES), 32'h293FF8);
    check("t4_pulse", 32'(bus.STEP_PULSE), 32'd1);
    tick(4);
    key[1] = 1'b1;
    tick(10);
    check("t4_once", 32'(bus.CODES), 32'h293FF8);
    key[1] = 1'b0;
    tick(1);
    key[1] = 1'b1;
    tick(10);
    check("t4_glitch", 32'(bus.CODES), 32'h293FF8);
    key[1] = 1'b0;
    tick(10);
    key[1] = 1'b1;
    tick(10);
    check("t4_second", 32'(bus.CODES), 32'h49FFC1);

    // Presses while running are dropped
    do_reset(2'b00);
    key[1] = 1'b0;
    tick(10);
    check("t4_run", 32'(bus.CODES), 32'h49FFC1);
    key[1] = 1'b1;
    tick(1);
    check("t4_run_step", 32'(bus.STEP_PULSE), 32'd0);

    // Reset on the edge a rotation is due
    do_reset(2'b00);
    tick(3);
    key[0] = 1'b0;
    tick(1);
    check("t5a_codes", 32'(bus.CODES), 32'h0527FF);
    check("t5a_paused", 32'(bus.PAUSED), 32'd0);
    check("t5a_step", 32'(bus.STEP_PULSE), 32'd0);
    key[0] = 1'b1;
    tick(3);
    check("t5a_no_late", 32'(bus.CODES), 32'h0527FF);
    tick(1);
    check("t5a_fresh", 32'(bus.CODES), 32'h293FF8);

    // Reset with an accepted press pending
    do_reset(2'b00);
    bus.SW = 2'b01;
    tick(3);
    key[1] = 1'b0;
    tick(5);
    key = 2'b10;
    tick(1);
    check("t5b_codes", 32'(bus.CODES), 32'h0527FF);
    check("t5b_paused", 32'(bus.PAUSED), 32'd0);
    check("t5b_step", 32'(bus.STEP_PULSE), 32'd0);
    key[0] = 1'b1;
    tick(3);
    check("t5b_repause", 32'(bus.PAUSED), 32'd1);
    tick(10);
    check("t5b_no_late", 32'(bus.CODES), 32'h0527FF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
